// File: rtl/match_pkg.sv
// match_pkg: shared types and helpers for the match controller.
//   match_state_t : READY / PLAY / ENDGAME match flow states
//   KEY_SPACE     : default start keycode (space bar)
//   popcount      : number of set bits in an up-to-8-bit vector
package match_pkg;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        PLAY    = 2'd1,
        ENDGAME = 2'd2
    } match_state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;

    function automatic logic [3:0] popcount(input logic [7:0] vec);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + 4'(vec[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/player_stock.sv
// player_stock: per-fighter stock tracker.
//   clk, reset_n : system clock, synchronous active-low reset
//   load_start   : reload lives with START_LIVES
//   play_en      : match is in PLAY; deaths count and timer runs only then
//   death        : death level (high while fighter is out of bounds)
//   lives        : remaining stock
//   alive        : lives != 0
//   invuln       : respawn invulnerability window active
module player_stock #(
    parameter int LIVES_W        = 3,
    parameter int START_LIVES    = 3,
    parameter int RESPAWN_CYCLES = 120
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_start,
    input  logic               play_en,
    input  logic               death,
    output logic [LIVES_W-1:0] lives,
    output logic               alive,
    output logic               invuln
);

    localparam int TIMER_W = $clog2(RESPAWN_CYCLES + 1);

    logic [TIMER_W-1:0] timer;
    logic               death_prev;
    logic               accept;

    // A death only counts on its rising edge, with stock left and no active window.
    assign accept = play_en && death && !death_prev && (lives != '0) && (timer == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lives      <= LIVES_W'(START_LIVES);
            timer      <= '0;
            death_prev <= 1'b0;
        end else begin
            death_prev <= death;

            if (load_start) begin
                lives <= LIVES_W'(START_LIVES);
            end else if (accept) begin
                lives <= lives - LIVES_W'(1);
            end

            // The final life lost starts no window; outside PLAY the window is cleared.
            if (!play_en) begin
                timer <= '0;
            end else if (accept && (lives != LIVES_W'(1))) begin
                timer <= TIMER_W'(RESPAWN_CYCLES);
            end else if (timer != '0) begin
                timer <= timer - TIMER_W'(1);
            end
        end
    end

    assign alive  = (lives != '0);
    assign invuln = (timer != '0);

endmodule

// File: rtl/match_controller.sv
// match_controller: READY -> PLAY -> ENDGAME match flow with per-player stocks.
//   clk, reset_n : system clock, synchronous active-low reset
//   keycode      : current keyboard keycode; START_KEY edge advances the flow
//   death        : per-player death levels
//   state        : match state (READY=0, PLAY=1, ENDGAME=2)
//   lives        : packed lives, player i at [i*LIVES_W +: LIVES_W]
//   alive        : per-player lives != 0
//   invuln       : per-player respawn window active
//   winner       : lowest surviving index, valid in ENDGAME
//   draw         : ENDGAME reached with no survivor
module match_controller
    import match_pkg::*;
#(
    parameter int         NUM_PLAYERS    = 2,
    parameter int         LIVES_W        = 3,
    parameter int         START_LIVES    = 3,
    parameter int         RESPAWN_CYCLES = 120,
    parameter logic [7:0] START_KEY      = KEY_SPACE
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [7:0]                       keycode,
    input  logic [NUM_PLAYERS-1:0]           death,
    output logic [1:0]                       state,
    output logic [NUM_PLAYERS*LIVES_W-1:0]   lives,
    output logic [NUM_PLAYERS-1:0]           alive,
    output logic [NUM_PLAYERS-1:0]           invuln,
    output logic [$clog2(NUM_PLAYERS)-1:0]   winner,
    output logic                             draw
);

    localparam int WIN_W = $clog2(NUM_PLAYERS);

    match_state_t     state_q;
    logic             key_prev;
    logic             key_now;
    logic             key_hit;
    logic             load_start;
    logic             play_en;
    logic [3:0]       live_count;
    logic [WIN_W-1:0] first_alive;

    assign key_now    = (keycode == START_KEY);
    assign key_hit    = key_now && !key_prev;
    assign live_count = popcount(8'(alive));
    assign play_en    = (state_q == PLAY);

    // Lives reload throughout READY and on the ENDGAME->READY edge itself,
    // so READY is entered already showing full stock.
    always_comb begin
        load_start = 1'b0;
        case (state_q)
            READY:   load_start = 1'b1;
            PLAY:    load_start = 1'b0;
            ENDGAME: load_start = key_hit;
            default: load_start = 1'b1;
        endcase
    end

    always_comb begin
        first_alive = '0;
        for (int unsigned i = NUM_PLAYERS; i > 0; i--) begin
            if (alive[i-1]) begin
                first_alive = WIN_W'(i - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= READY;
            key_prev <= 1'b0;
            winner   <= '0;
            draw     <= 1'b0;
        end else begin
            key_prev <= key_now;
            case (state_q)
                READY: begin
                    if (key_hit) begin
                        state_q <= PLAY;
                    end
                end
                PLAY: begin
                    if (live_count <= 4'd1) begin
                        state_q <= ENDGAME;
                        winner  <= first_alive;
                        draw    <= (live_count == 4'd0);
                    end
                end
                ENDGAME: begin
                    if (key_hit) begin
                        state_q <= READY;
                        winner  <= '0;
                        draw    <= 1'b0;
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

    assign state = state_q;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
        player_stock #(
            .LIVES_W        (LIVES_W),
            .START_LIVES    (START_LIVES),
            .RESPAWN_CYCLES (RESPAWN_CYCLES)
        ) u_stock (
            .clk        (clk),
            .reset_n    (reset_n),
            .load_start (load_start),
            .play_en    (play_en),
            .death      (death[g]),
            .lives      (lives[g*LIVES_W +: LIVES_W]),
            .alive      (alive[g]),
            .invuln     (invuln[g])
        );
    end

endmodule
